// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite fetch pipeline.
package sprite_pkg;

  localparam int unsigned DEF_SPR_W = 32;
  localparam int unsigned DEF_SPR_H = 32;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned ADDR_W    = 11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t DEF_TRANSP_KEY = rgb_t'(24'hFF00FF);

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_e;

endpackage

// File: rtl/sprite_fetch_if.sv
// Pixel stream in, sprite RAM port, and pixel stream out of the sprite fetcher.
interface sprite_fetch_if;
  import sprite_pkg::*;

  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               pix_valid;
  logic [ADDR_W-1:0]  read_address;
  rgb_t               ram_data;
  rgb_t               pix_rgb;
  logic               pix_hit;
  logic               pix_valid_out;

  // Fetcher side
  modport master (
    input  DrawX, DrawY, pix_valid, ram_data,
    output read_address, pix_rgb, pix_hit, pix_valid_out
  );

  // Display / RAM side
  modport slave (
    output DrawX, DrawY, pix_valid, ram_data,
    input  read_address, pix_rgb, pix_hit, pix_valid_out
  );

endinterface

// File: rtl/sprite_fetch.sv
// Sprite fetcher: per-pixel box test, sprite RAM addressing, transparency keying.
// Fixed 3-cycle latency from pix_valid to pix_valid_out, one pixel per cycle.
// Optional horizontal mirroring on face_left when SPRITE_MIRROR_EN is defined.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = DEF_SPR_W,
  parameter int unsigned SPR_H      = DEF_SPR_H,
  parameter rgb_t        TRANSP_KEY = DEF_TRANSP_KEY
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic               face_left,
  sprite_fetch_if.master     bus
);

  state_e state_q, state_d;
  logic   active_c;

  logic [COORD_W-1:0] sx_q, sx_d;
  logic [COORD_W-1:0] sy_q, sy_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               v1_q, v1_d, ib1_q, ib1_d;
  logic               v2_q, v2_d, ib2_q, ib2_d;
  rgb_t               rgb_q, rgb_d;
  logic               hit_q, hit_d;
  logic               vout_q, vout_d;

  logic [ADDR_W-1:0]  dx_c, dy_c, col_c, addr_c;
  logic               in_box_c, take_c, hit_c;

`ifdef SPRITE_MIRROR_EN
  logic face_q, face_d;
`else
  logic unused_face_c;
  assign unused_face_c = face_left;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= WAIT_FRAME;
    else          state_q <= state_d;
  end

  // Next state: leave WAIT_FRAME on the first frame_start, then stay ACTIVE
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: if (frame_start) state_d = ACTIVE;
      ACTIVE:     state_d = ACTIVE;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // FSM output decode
  always_comb begin
    active_c = 1'b0;
    if (state_q == ACTIVE) active_c = 1'b1;
  end

  // Stage 0: box test and address against the current (pre-update) shadows
  always_comb begin
    // 11-bit differences: a pixel left/above the sprite wraps to >= 1024, never in range
    dx_c     = {1'b0, bus.DrawX} - {1'b0, sx_q};
    dy_c     = {1'b0, bus.DrawY} - {1'b0, sy_q};
    in_box_c = (dx_c < ADDR_W'(SPR_W)) && (dy_c < ADDR_W'(SPR_H));
`ifdef SPRITE_MIRROR_EN
    col_c    = face_q ? (ADDR_W'(SPR_W - 1) - dx_c) : dx_c;
`else
    col_c    = dx_c;
`endif
    addr_c   = ADDR_W'(dy_c * ADDR_W'(SPR_W)) + col_c;
    take_c   = bus.pix_valid && active_c && in_box_c;
  end

  // Shadow updates and pipeline next values
  always_comb begin
    sx_d   = sx_q;
    sy_d   = sy_q;
    addr_d = addr_q;
    if (frame_start) begin
      sx_d = sprite_x;
      sy_d = sprite_y;
    end
    // Out-of-box pixels leave the RAM address untouched
    if (take_c) addr_d = addr_c;
    v1_d   = bus.pix_valid;
    ib1_d  = take_c;
    v2_d   = v1_q;
    ib2_d  = ib1_q;
    hit_c  = ib2_q && (bus.ram_data != TRANSP_KEY) && active_c;
    hit_d  = hit_c;
    rgb_d  = hit_c ? bus.ram_data : rgb_t'(24'h0);
    vout_d = v2_q;
  end

`ifdef SPRITE_MIRROR_EN
  // Facing direction shadow
  always_comb begin
    face_d = face_q;
    if (frame_start) face_d = face_left;
  end

  // Facing direction register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) face_q <= 1'b0;
    else          face_q <= face_d;
  end
`endif

  // Shadow and pipeline registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_q   <= '0;
      sy_q   <= '0;
      addr_q <= '0;
      v1_q   <= 1'b0;
      ib1_q  <= 1'b0;
      v2_q   <= 1'b0;
      ib2_q  <= 1'b0;
      rgb_q  <= rgb_t'(24'h0);
      hit_q  <= 1'b0;
      vout_q <= 1'b0;
    end else begin
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      addr_q <= addr_d;
      v1_q   <= v1_d;
      ib1_q  <= ib1_d;
      v2_q   <= v2_d;
      ib2_q  <= ib2_d;
      rgb_q  <= rgb_d;
      hit_q  <= hit_d;
      vout_q <= vout_d;
    end
  end

  assign bus.read_address  = addr_q;
  assign bus.pix_rgb       = rgb_q;
  assign bus.pix_hit       = hit_q;
  assign bus.pix_valid_out = vout_q;

endmodule

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 SHALL have parameters: SPR_W, default 32, sprite width in pixels; SPR_H, default 32, sprite height in pixels; TRANSP_KEY, default 24'hFF00FF, RGB colour treated as transparent.
REQ-002 SHALL have ports as listed in REQ-003 to REQ-015; one clock; reset is asynchronous and active-low.
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 frame_start  input  1  single-cycle pulse at start of vertical blank.
REQ-006 sprite_x  input  10  sprite top-left column, sampled on frame_start.
REQ-007 sprite_y  input  10  sprite top-left row, sampled on frame_start.
REQ-008 DrawX  input  10  current pixel column.
REQ-009 DrawY  input  10  current pixel row.
REQ-010 pix_valid  input  1  DrawX/DrawY valid this cycle.
REQ-011 face_left  input  1  facing direction, sampled on frame_start.
REQ-012 read_address  output  11  sprite RAM read address.
REQ-013 ram_data  input  24  sprite RAM read data, one cycle after read_address.
REQ-014 pix_rgb  output  24  sprite pixel colour.
REQ-015 pix_hit, pix_valid_out  output  1 each  opaque sprite pixel; output qualifier.

Function
REQ-016 SHALL implement FSM WAIT_FRAME -> ACTIVE on first frame_start; ACTIVE holds until reset; in WAIT_FRAME, pix_hit SHALL be 0.
REQ-017 SHALL latch sprite_x, sprite_y, face_left into shadow registers on frame_start; pixels in flight SHALL use shadow values.
REQ-018 frame_start coincident with pix_valid SHALL use the pre-update shadow position for that pixel.
REQ-019 In-box test: DrawX-sx in [0,SPR_W-1] and DrawY-sy in [0,SPR_H-1], 11-bit unsigned, no wrap; sx+SPR_W beyond 639 SHALL NOT alias to column 0.
REQ-020 Address = row*SPR_W + col, zero-extended to 11 bits; registered at stage 1; outside box, read_address SHALL hold its previous value.
REQ-021 Pipeline: pixel on cycle N -> read_address valid N+1 -> ram_data valid N+2 -> pix_rgb/pix_hit/pix_valid_out registered, visible N+3; fixed 3-cycle latency, one pixel per cycle, no stalls.
REQ-022 pix_valid_out SHALL equal pix_valid delayed 3 cycles.
REQ-023 pix_hit = in_box(delayed) AND ram_data != TRANSP_KEY AND state==ACTIVE; pix_rgb = ram_data when pix_hit, else 24'h0.

Reset
REQ-024 Reset_n low SHALL asynchronously clear: state=WAIT_FRAME, shadows=0, read_address=0, pix_rgb=0, pix_hit=0, pix_valid_out=0, all pipeline valid/in-box bits=0.
REQ-025 Reset asserted mid-line SHALL discard in-flight pixels; no pix_valid_out for 3 cycles after release.

Configuration
REQ-026 With SPRITE_MIRROR_EN defined, col SHALL be (SPR_W-1)-(DrawX-sx) when shadow face_left=1, else DrawX-sx.
REQ-027 Without SPRITE_MIRROR_EN, face_left SHALL be ignored and col = DrawX-sx.

Structure
REQ-028 Package sprite_pkg SHALL hold SPR_W/SPR_H defaults, TRANSP_KEY, rgb_t (24-bit) and the FSM state enum.
REQ-029 No sub-module; sprite RAM instantiated outside, connected via read_address/ram_data.

Verification
REQ-030 Reset, frame_start with sx=100, sy=50; pixel (100,50) -> read_address=0 at N+1, pix_hit at N+3 with ram_data word 0.
REQ-031 Pixel (131,81) -> address 1023, hit; pixel (132,81) -> pix_hit=0, pix_rgb=0.
REQ-032 RAM word = 24'hFF00FF inside box -> pix_hit=0, pix_valid_out=1.
REQ-033 With SPRITE_MIRROR_EN, face_left=1, pixel (100,50) -> read_address=31; without macro -> 0.
REQ-034 sx=630, pixel DrawX=5 -> pix_hit=0 (no wrap); frame_start coincident with pixel -> old position used.
REQ-035 Before first frame_start any pixel -> pix_hit=0; Reset_n pulse mid-stream -> outputs 0 immediately, pix_valid_out low 3 cycles after release.
